mem_wb_stage: RTL and testbench

- Consumer end of the execute-stage result interface; sits between execute and the register file.
- Accepts one instruction's execute results: 14-bit control word, calculated address, ALU result, pc+4 and store data.
- Performs the data-memory access over a req/ack handshake, sign/zero-extends load data, and selects the writeback value.
- Issues the PC redirect for taken branches and jumps.

---
 rtl/mem_wb_stage_if.sv | 24 ++
 rtl/mem_wb_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Execute-result bus between the execute stage (master) and the
// memory/writeback stage (slave). One instruction transfers when
// in_valid and in_ready are both high on a rising clock edge.
interface mem_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] control_word_ex;
  logic [31:0] calculated_adr;
  logic [31:0] alu_result;
  logic [31:0] pc_plus_4_ex;
  logic [31:0] regfileb_ex;

  modport master (
    output in_valid, control_word_ex, calculated_adr, alu_result,
           pc_plus_4_ex, regfileb_ex,
    input  in_ready
  );

  modport slave (
    input  in_valid, control_word_ex, calculated_adr, alu_result,
           pc_plus_4_ex, regfileb_ex,
    output in_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: latches one instruction's execute results,
// performs the data-memory access over a req/ack handshake, extends load
// data, produces the register writeback and the PC redirect.
module mem_wb_stage #(
  parameter int ACK_TIMEOUT = 255  // 0 disables the ack timeout
) (
  input  logic        clk,
  input  logic        rst,
  mem_wb_stage_if.slave ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  typedef struct packed {
    logic       branch_taken;
    logic       rf_wb;
    logic       mem_we;
    logic [1:0] wb_src;
    logic       pc_src;
    logic [4:0] rd;
    logic [2:0] funct3;
  } ctrl_t;

  // Counter only needs to reach ACK_TIMEOUT-1.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t           state_q, state_d;
  ctrl_t            in_ctrl, ctrl_q;
  logic [31:0]      adr_q, alu_q, pc4_q, store_q, ld_data_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;

  logic        accept, in_mem, in_fault, f3_legal, aligned, timeout_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign in_ctrl     = ctrl_t'(ex.control_word_ex);
  assign ex.in_ready = (state_q == IDLE);
  assign accept      = ex.in_valid & ex.in_ready;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Classify the incoming op and decide whether it may reach memory.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    f3_legal = 1'b0;
    aligned  = 1'b1;
    in_mem   = in_ctrl.mem_we | (in_ctrl.wb_src == 2'b01);
    unique case (in_ctrl.funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~in_ctrl.mem_we;
      default:                f3_legal = 1'b0;
    endcase
    unique case (in_ctrl.funct3[1:0])
      2'b01:   aligned = ~ex.calculated_adr[0];
      2'b10:   aligned = (ex.calculated_adr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    in_fault = in_mem & ~(f3_legal & aligned);
  end

  // Select and extend the addressed byte/half of the returned word.
  always_comb begin
    ld_byte = dmem_rdata[8*adr_q[1:0] +: 8];
    ld_half = adr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (ctrl_q.funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // State register; reset aborts any outstanding request immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (in_mem & ~in_fault) ? REQ : WB;
      REQ:  if (dmem_ack | timeout_hit) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the instruction on accept; capture load data / timeout in REQ.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset so that every output reads 0 out of reset.
    if (rst) begin
      ctrl_q    <= '0;
      adr_q     <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
      store_q   <= '0;
      ld_data_q <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      ctrl_q  <= in_ctrl;
      adr_q   <= ex.calculated_adr;
      alu_q   <= ex.alu_result;
      pc4_q   <= ex.pc_plus_4_ex;
      store_q <= ex.regfileb_ex;
      fault_q <= in_fault;
      cnt_q   <= '0;
    end else if (state_q == REQ) begin
      if (dmem_ack)         ld_data_q <= ld_ext;
      else if (timeout_hit) fault_q   <= 1'b1;
      else                  cnt_q     <= cnt_q + 1'b1;
    end
  end

  // Memory bus during REQ, writeback/redirect during WB, zero otherwise.
  always_comb begin
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_be        = '0;
    dmem_wdata     = '0;
    wb_valid       = 1'b0;
    wb_we          = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_fault      = 1'b0;
    if (state_q == REQ) begin
      dmem_req  = 1'b1;
      dmem_we   = ctrl_q.mem_we;
      dmem_addr = {adr_q[31:2], 2'b00};
      dmem_be   = 4'b1111;
      if (ctrl_q.mem_we) begin
        unique case (ctrl_q.funct3[1:0])
          2'b00: begin
            dmem_be    = 4'b0001 << adr_q[1:0];
            dmem_wdata = {4{store_q[7:0]}};
          end
          2'b01: begin
            dmem_be    = 4'b0011 << adr_q[1:0];
            dmem_wdata = {2{store_q[15:0]}};
          end
          default: dmem_wdata = store_q;
        endcase
      end
    end
    if (state_q == WB) begin
      wb_valid       = 1'b1;
      wb_we          = ctrl_q.rf_wb & (ctrl_q.rd != 5'd0) & ~fault_q;
      wb_rd          = ctrl_q.rd;
      mem_fault      = fault_q;
      redirect_valid = (ctrl_q.branch_taken | ctrl_q.pc_src) & ~fault_q;
      redirect_pc    = ctrl_q.pc_src ? {adr_q[31:1], 1'b0} : adr_q;
      unique case (ctrl_q.wb_src)
        2'b00:   wb_data = alu_q;
        2'b01:   wb_data = ld_data_q;
        2'b10:   wb_data = pc4_q;
        default: wb_data = adr_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected writebacks are queued when an
// instruction is sent and compared when wb_valid appears.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, redirect_valid, mem_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];

  mem_wb_stage_if ex_if ();

  mem_wb_stage #(.ACK_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex             (ex_if.slave),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_fault      (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                      input logic rv, input logic [31:0] rpc, input logic fault);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.rv = rv; e.rpc = rpc; e.fault = fault;
    sb_q.push_back(e);
  endtask

  // Present one instruction for a single accept cycle.
  task automatic send(input logic bt, input logic rf, input logic mw, input logic [1:0] src,
                      input logic ps, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [31:0] adr, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [31:0] b);
    @(negedge clk);
    check("in_ready_idle", {31'd0, ex_if.in_ready}, 32'd1);
    ex_if.control_word_ex = {bt, rf, mw, src, ps, rd, f3};
    ex_if.calculated_adr  = adr;
    ex_if.alu_result      = alu;
    ex_if.pc_plus_4_ex    = pc4;
    ex_if.regfileb_ex     = b;
    ex_if.in_valid        = 1'b1;
    @(negedge clk);
    ex_if.in_valid        = 1'b0;
  endtask

  // Act as memory (ack in the ack_delay-th request cycle, 0 = never) and
  // compare the writeback against the scoreboard head.
  task automatic run_op(input string tag, input int ack_delay, input logic [31:0] rdata,
                        input int exp_req, input logic exp_we, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int   req_cnt = 0;
    logic found   = 1'b0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({tag, "_addr"}, dmem_addr, exp_addr);
          check({tag, "_we"}, {31'd0, dmem_we}, {31'd0, exp_we});
          check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
          if (exp_we) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        end
        dmem_ack = (req_cnt == ack_delay);
        if (dmem_ack) dmem_rdata = rdata;
      end else begin
        dmem_ack = 1'b0;
      end
      if (wb_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    n_checks++;
    if (!found) begin
      n_errors++;
      $error("FAIL %s_wb_timeout: observed=no wb_valid expected=wb_valid", tag);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s_sb_empty: observed=wb_valid expected=no writeback", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_req_cycles"}, req_cnt, exp_req);
      check({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, e.we});
      check({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
      check({tag, "_wb_data"}, wb_data, e.data);
      check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.rv});
      if (e.rv) check({tag, "_redirect_pc"}, redirect_pc, e.rpc);
      check({tag, "_mem_fault"}, {31'd0, mem_fault}, {31'd0, e.fault});
    end
    @(negedge clk);
    check({tag, "_wb_single"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    int late_wb;
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    ex_if.in_valid = 1'b0;
    ex_if.control_word_ex = '0;
    ex_if.calculated_adr = '0;
    ex_if.alu_result = '0;
    ex_if.pc_plus_4_ex = '0;
    ex_if.regfileb_ex = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, ex_if.in_ready}, 32'd1);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
    rst = 1'b0;

    // ALU op, rd=5
    push(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd5, 3'b000, 32'h0, 32'h1234, 32'h0, 32'h0);
    run_op("alu", 0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

    // ALU op to x0: no register write
    push(1'b0, 5'd0, 32'h55AA, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 3'b000, 32'h0, 32'h55AA, 32'h0, 32'h0);
    run_op("alu_x0", 0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

    // LB at 0x1003, ack in third request cycle
    push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 3'b000, 32'h1003, 32'h0, 32'h0, 32'h0);
    run_op("lb", 3, 32'h80FF_FF00, 3, 1'b0, 32'h1000, 4'hF, 32'h0);

    // LBU at 0x1003
    push(1'b1, 5'd7, 32'h0000_0080, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 3'b100, 32'h1003, 32'h0, 32'h0, 32'h0);
    run_op("lbu", 3, 32'h80FF_FF00, 3, 1'b0, 32'h1000, 4'hF, 32'h0);

    // LH at 0x6002: upper half sign-extended
    push(1'b1, 5'd9, 32'hFFFF_8001, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 3'b001, 32'h6002, 32'h0, 32'h0, 32'h0);
    run_op("lh", 1, 32'h8001_7FFF, 1, 1'b0, 32'h6000, 4'hF, 32'h0);

    // SH at 0x2002
    push(1'b0, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd3, 3'b001, 32'h2002, 32'h0, 32'h0, 32'hDEAD_BEEF);
    run_op("sh", 2, 32'h0, 2, 1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF);

    // SB at 0x5001
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 3'b000, 32'h5001, 32'h0, 32'h0, 32'h1234_5678);
    run_op("sb", 1, 32'h0, 1, 1'b1, 32'h5000, 4'b0010, 32'h7878_7878);

    // Misaligned LW: fault, no request
    push(1'b0, 5'd4, 32'h0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 3'b010, 32'h2001, 32'h0, 32'h0, 32'h0);
    run_op("lw_misaligned", 1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Illegal load funct3 011: fault, no request
    push(1'b0, 5'd4, 32'h0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 3'b011, 32'h2000, 32'h0, 32'h0, 32'h0);
    run_op("ld_f3_011", 1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Misaligned SW: fault, no store issued
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 3'b010, 32'h3002, 32'h0, 32'h0, 32'hFFFF_FFFF);
    run_op("sw_misaligned", 1, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0);

    // LW with no ack: request held exactly 4 cycles, then fault
    push(1'b0, 5'd6, 32'h0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd6, 3'b010, 32'h3000, 32'h0, 32'h0, 32'h0);
    run_op("lw_timeout", 0, 32'h0, 4, 1'b0, 32'h3000, 4'hF, 32'h0);

    // JALR: link value and redirect with bit 0 cleared
    push(1'b1, 5'd1, 32'h0000_0100, 1'b1, 32'h0000_4004, 1'b0);
    send(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 5'd1, 3'b000, 32'h4005, 32'h0, 32'h100, 32'h0);
    run_op("jalr", 0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Taken branch: redirect target unmodified, no register write
    push(1'b0, 5'd2, 32'h0, 1'b1, 32'h8000_0011, 1'b0);
    send(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd2, 3'b000, 32'h8000_0011, 32'h0, 32'h0, 32'h0);
    run_op("branch", 0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset in the middle of a request; a late ack must be ignored
    send(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd8, 3'b010, 32'h7000, 32'h0, 32'h0, 32'h0);
    check("midreq_req_before", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1 check("midreq_req_async_drop", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    late_wb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (wb_valid) late_wb++;
    end
    check("midreq_late_ack_wb", late_wb, 0);
    check("midreq_in_ready", {31'd0, ex_if.in_ready}, 32'd1);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
